// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and a line-wide backing memory.
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics outputs.
module dcache_responder #(
  parameter int INDEX_W = 4,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 32 - 5 - INDEX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]         state_r;
  logic [LINES-1:0]   valid_r;
  logic [LINES-1:0]   dirty_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [LINE_W-1:0]  data_r [LINES];

  logic               mem_req_r;
  logic               mem_we_r;
  logic [31:0]        mem_addr_r;
  logic [LINE_W-1:0]  mem_data_r;

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [2:0]         word_s;
  logic               idle_s;
  logic               hit_s;
  logic               ack_s;
  logic               store_hit_s;
  logic               fill_s;
  logic               wb_done_s;
  logic               unused_s;

  assign idx_s       = cpu_addr_i[5+INDEX_W-1:5];
  assign tag_s       = cpu_addr_i[31:5+INDEX_W];
  assign word_s      = cpu_addr_i[4:2];
  assign unused_s    = ^cpu_addr_i[1:0];

  assign idle_s      = (state_r == IDLE);
  assign hit_s       = cpu_req_i & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  // An ack arriving with no request outstanding is ignored.
  assign ack_s       = mem_ack_i & mem_req_r;
  assign store_hit_s = idle_s & hit_s & cpu_we_i;
  assign fill_s      = (state_r == ALLOCATE) & ack_s;
  assign wb_done_s   = (state_r == WRITEBACK) & ack_s;

  assign cpu_stall_o = ~idle_s | (cpu_req_i & ~hit_s);

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_data_o  = mem_data_r;

  // Load data mux: selected word on a load hit, zero otherwise.
  always_comb begin
    cpu_data_o = 32'd0;
    if (idle_s & hit_s & ~cpu_we_i) begin
      cpu_data_o = data_r[idx_s][{word_s, 5'd0} +: 32];
    end else begin
      cpu_data_o = 32'd0;
    end
  end

  // Miss-handling FSM and registered backing-memory request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= 32'd0;
      mem_data_r <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_req_i & ~hit_s) begin
            mem_req_r <= 1'b1;
            if (valid_r[idx_s] & dirty_r[idx_s]) begin
              state_r    <= WRITEBACK;
              mem_we_r   <= 1'b1;
              mem_addr_r <= {tag_r[idx_s], idx_s, 5'd0};
              mem_data_r <= data_r[idx_s];
            end else begin
              state_r    <= ALLOCATE;
              mem_we_r   <= 1'b0;
              mem_addr_r <= {tag_s, idx_s, 5'd0};
            end
          end
        end
        WRITEBACK: begin
          // Request stays high straight into the fill.
          if (ack_s) begin
            state_r    <= ALLOCATE;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {tag_s, idx_s, 5'd0};
          end
        end
        ALLOCATE: begin
          if (ack_s) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  // Line status bits: fill validates, write-back cleans, store hit dirties.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
      dirty_r[idx_s] <= 1'b0;
    end else if (wb_done_s) begin
      dirty_r[idx_s] <= 1'b0;
    end else if (store_hit_s) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until valid is set.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      data_r[idx_s] <= mem_data_i;
      tag_r[idx_s]  <= tag_s;
    end else if (store_hit_s) begin
      data_r[idx_s][{word_s, 5'd0} +: 32] <= cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_r;
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  assign hit_cnt_o  = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;

  // Access statistics; the completing hit right after a refill is not a hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refill_r   <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      refill_r <= fill_s;
      if (idle_s & hit_s & ~refill_r) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (idle_s & cpu_req_i & ~hit_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule
